secded_correct_pipe: RTL
========================

Name: secded_correct_pipe

Overview:
- Parametrised, pipelined SEC-DED (extended Hamming) decode-and-correct stage.
- Next generation of the team's combinational syndrome-decode/XNOR-correct netlists: width generalised; valid/ready pipeline, detect-only mode and saturating error counters added.
- Sits on a memory or link read path. Takes a raw codeword; returns corrected data with per-word error flags.

Parameters:
- DATA_W, 32, data width in bits (4..64).
- P, derived (localparam), smallest p with 2^p >= DATA_W+p+1; 6 for DATA_W=32, 4 for DATA_W=8.
- N, derived (localparam), DATA_W+P; highest Hamming position.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  stage can accept a codeword.
- in_cw  in  N+1  codeword; bit i = Hamming position i, bit 0 = overall parity.
- corr_en  in  1  1 = correct single errors; 0 = detect only. Sampled with in_cw.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  decoded data.
- out_corr  out  1  single error detected (corrected when corr_en=1).
- out_uncorr  out  1  uncorrectable error detected.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  saturating count of delivered words with out_corr=1.
- uncorr_cnt  out  CNT_W  saturating count of delivered words with out_uncorr=1.

Behaviour:
- Layout: check bits at positions 1,2,4,…,2^(P-1). Data bits fill the remaining positions 3..N in ascending order; data[0] is at position 3.
- Stage 1 (registered):
  - syndrome s = XOR of all indices i in 1..N with in_cw[i]=1.
  - q = XOR of in_cw[N:0].
  - Raw data and corr_en are captured alongside.
- Stage 2 (registered) classifies each word:
  - s=0, q=0: clean. corr=0, uncorr=0.
  - q=1, s<=N: single error. corr=1. If corr_en=1, flip bit s before data extraction. s=0 or s a power of two means a check-bit error and data is unchanged.
  - q=1, s>N: uncorr=1, data raw.
  - q=0, s!=0: double error. uncorr=1, data raw.
  - corr and uncorr are never both 1.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready is held high. Throughput is 1 word/cycle.
- Flow control:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - Both stages shift only when advance=1.
  - A stage-1 bubble is not collapsed while stage 2 stalls.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_corr and out_uncorr hold stable.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) only.
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt has priority over a same-cycle increment: the result is 0 and that event is not counted.
- Reset values: out_valid=0, out_data=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0, all stage valids=0.
- Reset mid-operation discards in-flight words. in_ready=1 in the cycle after reset deasserts.
- No X propagation: the data registers of invalid stages may hold stale values, but the outputs above are defined by their reset values.

Test Plan:
- DATA_W=8 (N=12), in_cw=0, corr_en=1, out_ready=1 -> 2 cycles later out_data=0x00, corr=0, uncorr=0; counters unchanged.
- DATA_W=8, in_cw=13'h0020 (position 5 flipped), corr_en=1 -> out_data=0x00, corr=1, corr_cnt=1. Same input with corr_en=0 -> out_data=0x02, corr=1.
- DATA_W=8, in_cw=13'h0028 (positions 3 and 5) -> s=6, q=0, uncorr=1, out_data=0x03, uncorr_cnt=1.
- DATA_W=8, in_cw=13'h0112 (positions 1,4,8) -> s=13>N, q=1, uncorr=1.
- DATA_W=8, in_cw=13'h0001 -> corr=1, out_data=0x00.
- Stream 4 words with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, no word lost or duplicated, output held stable.
- CNT_W=2: deliver 5 single-error words -> corr_cnt saturates at 3.
- Assert clr_cnt in the same cycle as an output handshake -> corr_cnt=0.
- Assert rst with 2 words in flight -> out_valid=0 next cycle; neither word is ever delivered.

Source files
------------

// File: rtl/secded_correct_pipe.sv
// Two-stage SEC-DED (extended Hamming) decode-and-correct pipeline.
// Stage 1 computes the syndrome and overall parity. Stage 2 classifies the
// word, optionally corrects one bit, and extracts the data. Both stages
// share one advance enable, so a stall freezes the whole pipe, bubbles
// included. Two saturating counters record delivered error words.
module secded_correct_pipe #(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    // Smallest p with 2^p >= DATA_W+p+1, valid for DATA_W in 4..64.
    localparam int P      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int N      = DATA_W + P
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N:0]        in_cw,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [P-1:0] N_S = P'(N);

    // Data occupies every non-power-of-two position from 3 upward, in order.
    function automatic logic [DATA_W-1:0] extract(input logic [N:0] cw);
        logic [DATA_W-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int i = 3; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

    logic              advance;
    logic              hs_out;

    logic              v1_q;
    logic [P-1:0]      syn_q;
    logic              par_q;
    logic [N:0]        cw_q;
    logic              ce_q;

    logic [P-1:0]      syn_d;
    logic              par_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] data_q;
    logic              corr_q;
    logic              uncorr_q;

    logic              single_d;
    logic              uncorr_d;
    logic [N:0]        cw_fix_d;
    logic [DATA_W-1:0] data_d;

    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  uncorr_cnt_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign hs_out   = out_valid_q && out_ready;

    // Syndrome is the XOR of the indices of all set positions; q is total parity.
    always_comb begin
        syn_d = '0;
        for (int i = 1; i <= N; i++) begin
            if (in_cw[i]) syn_d = syn_d ^ P'(i);
        end
        par_d = ^in_cw;
    end

    // Stage 1 register: syndrome, parity, raw word and mode travel together.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (advance) begin
            v1_q  <= in_valid;
            syn_q <= syn_d;
            par_q <= par_d;
            cw_q  <= in_cw;
            ce_q  <= corr_en;
        end
    end

    // Classify and correct. A syndrome of 0 or a power of two with odd parity
    // points at a check bit, so flipping it leaves the data untouched.
    always_comb begin
        single_d = par_q && (syn_q <= N_S);
        uncorr_d = (par_q && (syn_q > N_S)) || (!par_q && (syn_q != '0));
        cw_fix_d = cw_q;
        if (single_d && ce_q) cw_fix_d[syn_q] = ~cw_q[syn_q];
        data_d = extract(cw_fix_d);
    end

    // Stage 2 register: only real words overwrite the visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            corr_q      <= 1'b0;
            uncorr_q    <= 1'b0;
        end else if (advance) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                data_q   <= data_d;
                corr_q   <= single_d;
                uncorr_q <= uncorr_d;
            end
        end
    end

    // Saturating error counters; clear beats a same-cycle delivery.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (hs_out) begin
            if (corr_q && (corr_cnt_q != '1))     corr_cnt_q   <= corr_cnt_q + 1'b1;
            if (uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign out_corr   = corr_q;
    assign out_uncorr = uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule
